// File: rtl/vme_script_sequencer.sv
// Script-driven VME command sequencer: a host loads WRITE/READ/DELAY/END entries,
// then the script is replayed over a ready/valid command interface with masked read-back.
module vme_script_sequencer #(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned DATA_W   = 16,
  parameter logic [31:0] CMD_MASK = 32'h00a80000,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned ERR_W    = 16,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [1:0]        ld_op,
  input  logic [31:0]       ld_cmd,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] ld_mask,
  input  logic              ld_clr,
  output logic              full,
  input  logic              go,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              start,
  input  logic              vme_cmd_rd,
  output logic [31:0]       vme_cmd_reg,
  output logic [DATA_W-1:0] vme_dat_reg_in,
  input  logic              vme_dat_wr,
  input  logic [DATA_W-1:0] vme_dat_reg_out,
  output logic              rsp_valid,
  output logic [AW-1:0]     rsp_idx,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [AW-1:0]     first_err_idx,
  output logic              timeout_flag
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_DELAY, OP_END} op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_RSP, S_DELAY, S_NEXT, S_DONE
  } state_e;

  typedef struct packed {
    op_e               op;
    logic [31:0]       cmd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } entry_t;

  entry_t mem_q [DEPTH];
  entry_t ent_q;

  state_e            state_q, state_d;
  logic [AW:0]       ld_ptr_q, ld_ptr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       dly_q, dly_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [AW-1:0]     rsp_idx_q, rsp_idx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [AW-1:0]     first_err_q, first_err_d;
  logic              tflag_q, tflag_d;
  logic              mem_we;
  logic              err_inc;
  logic              mismatch;

  assign full     = (ld_ptr_q == (AW+1)'(DEPTH));
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign start    = (state_q == S_ISSUE) && !abort;
  assign mismatch = |((vme_dat_reg_out ^ ent_q.data) & ent_q.mask);

  always_comb begin
    vme_cmd_reg    = CMD_MASK;
    vme_dat_reg_in = '0;
    if (start) begin
      vme_cmd_reg = ent_q.cmd | CMD_MASK
                  | ((ent_q.op == OP_READ)  ? 32'h0200_0000 : 32'h0)
                  | ((ent_q.op == OP_WRITE) ? 32'h0100_0000 : 32'h0);
      if (ent_q.op == OP_WRITE) vme_dat_reg_in = ent_q.data;
    end
  end

  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    dly_d       = dly_q;
    rsp_valid_d = 1'b0;
    rsp_idx_d   = rsp_idx_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    tflag_d     = tflag_q;
    mem_we      = 1'b0;
    err_inc     = 1'b0;

    // abort wins over everything in-flight, including a same-cycle response
    if (abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            err_d       = '0;
            first_err_d = '0;
            tflag_d     = 1'b0;
            idx_d       = '0;
            state_d     = (ld_ptr_q == '0) ? S_DONE : S_FETCH;
          end else if (ld_clr) begin
            ld_ptr_d = '0;
          end else if (ld_en && !full) begin
            mem_we   = 1'b1;
            ld_ptr_d = ld_ptr_q + 1'b1;
          end
        end
        S_FETCH: begin
          if ({1'b0, idx_q} == ld_ptr_q || ent_q.op == OP_END) begin
            state_d = S_DONE;
          end else if (ent_q.op == OP_DELAY) begin
            dly_d   = ent_q.cmd[15:0];
            state_d = S_DELAY;
          end else begin
            tmo_d   = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (vme_cmd_rd) begin
            tmo_d   = '0;
            state_d = (ent_q.op == OP_READ) ? S_WAIT_RSP : S_NEXT;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_inc = 1'b1;
            tflag_d = 1'b1;
            state_d = S_NEXT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_WAIT_RSP: begin
          if (vme_dat_wr) begin
            rsp_valid_d = 1'b1;
            rsp_idx_d   = idx_q;
            rsp_data_d  = vme_dat_reg_out;
            err_inc     = mismatch;
            state_d     = S_NEXT;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_inc = 1'b1;
            tflag_d = 1'b1;
            state_d = S_NEXT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_DELAY: begin
          if (dly_q <= 16'd1) state_d = S_NEXT;
          else                dly_d   = dly_q - 16'd1;
        end
        S_NEXT: begin
          if (idx_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    if (err_inc) begin
      if (err_q != '1) err_d = err_q + 1'b1;
      if (err_q == '0) first_err_d = idx_q;
    end
  end

  // Synchronous read addressed by idx_d, so ent_q already holds entry idx in FETCH
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ld_ptr_q[AW-1:0]] <= {op_e'(ld_op), ld_cmd, ld_data, ld_mask};
    ent_q <= mem_q[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ld_ptr_q    <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      dly_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      dly_q       <= dly_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      tflag_q     <= tflag_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_idx       = rsp_idx_q;
  assign rsp_data      = rsp_data_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_err_q;
  assign timeout_flag  = tflag_q;

endmodule

// File: tb/tb_vme_script_sequencer.sv
// Bench for vme_script_sequencer: scoreboarded VME beats/responses, a read-compare
// vector table and hand-written timeout, delay, full, abort and reset sequences.
module tb_vme_script_sequencer;

  localparam int DEPTH = 64;
  localparam int DW    = 16;
  localparam int TMO   = 16;
  localparam int AW    = 6;
  localparam logic [31:0] CMASK = 32'h00a80000;
  localparam logic [1:0] OPW = 2'd0, OPR = 2'd1, OPD = 2'd2, OPE = 2'd3;

  logic clk, rst_n;
  logic ld_en, ld_clr, full, go, abort, busy, done, start;
  logic [1:0] ld_op;
  logic [31:0] ld_cmd, vme_cmd_reg;
  logic [DW-1:0] ld_data, ld_mask, vme_dat_reg_in, vme_dat_reg_out, rsp_data;
  logic vme_cmd_rd, vme_dat_wr, rsp_valid, timeout_flag;
  logic [AW-1:0] rsp_idx, first_err_idx;
  logic [15:0] err_cnt;

  vme_script_sequencer #(.DEPTH(DEPTH), .DATA_W(DW), .CMD_MASK(CMASK),
                         .TIMEOUT(TMO), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_op(ld_op), .ld_cmd(ld_cmd),
    .ld_data(ld_data), .ld_mask(ld_mask), .ld_clr(ld_clr), .full(full),
    .go(go), .abort(abort), .busy(busy), .done(done), .start(start),
    .vme_cmd_rd(vme_cmd_rd), .vme_cmd_reg(vme_cmd_reg),
    .vme_dat_reg_in(vme_dat_reg_in), .vme_dat_wr(vme_dat_wr),
    .vme_dat_reg_out(vme_dat_reg_out), .rsp_valid(rsp_valid), .rsp_idx(rsp_idx),
    .rsp_data(rsp_data), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] cmd; logic [15:0] dat; } beat_t;
  typedef struct { logic [5:0] idx; logic [15:0] dat; } rsp_t;
  typedef struct { logic [15:0] exp_d; logic [15:0] mask; logic [15:0] rsp; logic [15:0] err; } rvec_t;

  beat_t       beat_q[$];
  rsp_t        rsp_exp_q[$];
  logic [15:0] resp_q[$];
  int          acc_times[$];
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // VME-side model: checks accepted beats and responses, answers READs two cycles later
  initial begin
    int dly;
    logic [15:0] rv;
    dly = 0;
    rv = '0;
    vme_dat_wr = 1'b0;
    vme_dat_reg_out = '0;
    forever begin
      @(negedge clk);
      vme_dat_wr = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          vme_dat_wr = 1'b1;
          vme_dat_reg_out = rv;
        end
      end
      if (start && vme_cmd_rd) begin
        acc_cnt++;
        acc_times.push_back(cyc);
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got cmd 0x%08h", vme_cmd_reg);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_cmd", vme_cmd_reg, b.cmd);
          chk("beat_dat", {16'h0, vme_dat_reg_in}, {16'h0, b.dat});
        end
        if (vme_cmd_reg[25] && resp_q.size() > 0) begin
          rv = resp_q.pop_front();
          dly = 2;
        end
      end
      if (rsp_valid) begin
        if (rsp_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got idx %0d data 0x%04h", rsp_idx, rsp_data);
        end else begin
          rsp_t r;
          r = rsp_exp_q.pop_front();
          chk("rsp_idx", {26'h0, rsp_idx}, {26'h0, r.idx});
          chk("rsp_data", {16'h0, rsp_data}, {16'h0, r.dat});
        end
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [1:0] op, input logic [31:0] cmd, input logic [15:0] d, input logic [15:0] m);
    ld_en = 1'b1; ld_op = op; ld_cmd = cmd; ld_data = d; ld_mask = m;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic clr();
    ld_clr = 1'b1; tick(); ld_clr = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0;
  endtask

  task automatic push_beat(input logic [31:0] c, input logic [15:0] d);
    beat_t b;
    b.cmd = c; b.dat = d;
    beat_q.push_back(b);
  endtask

  task automatic push_rsp(input logic [15:0] d);
    rsp_t r;
    r.idx = '0; r.dat = d;
    resp_q.push_back(d);
    rsp_exp_q.push_back(r);
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk({nm, "_done"}, {31'h0, seen}, 32'd1);
    tick();
    chk({nm, "_beats_left"}, beat_q.size(), 32'd0);
    chk({nm, "_rsps_left"}, rsp_exp_q.size(), 32'd0);
  endtask

  task automatic wait_start(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) begin seen = 1'b1; break; end
    end
    chk({nm, "_start"}, {31'h0, seen}, 32'd1);
  endtask

  initial begin
    rvec_t tbl[4];
    int a0, d0, n, gaps[2];
    bit stable;

    tbl[0] = '{exp_d: 16'hBEEF, mask: 16'hFFFF, rsp: 16'hBEEF, err: 16'd0};
    tbl[1] = '{exp_d: 16'hBEEF, mask: 16'hFFFF, rsp: 16'hBEEE, err: 16'd1};
    tbl[2] = '{exp_d: 16'h0050, mask: 16'h00F0, rsp: 16'hFF5F, err: 16'd0};
    tbl[3] = '{exp_d: 16'h0050, mask: 16'h00F0, rsp: 16'h0060, err: 16'd1};

    rst_n = 1'b0; ld_en = 1'b0; ld_clr = 1'b0; ld_op = '0; ld_cmd = '0;
    ld_data = '0; ld_mask = '0; go = 1'b0; abort = 1'b0; vme_cmd_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", {31'h0, start}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_cmd_reg", vme_cmd_reg, CMASK);
    chk("rst_dat_in", {16'h0, vme_dat_reg_in}, 32'd0);
    chk("rst_err", {16'h0, err_cnt}, 32'd0);
    chk("rst_tflag", {31'h0, timeout_flag}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_first_err", {26'h0, first_err_idx}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single WRITE
    clr();
    load(OPW, 32'h00004100, 16'h1234, 16'h0);
    load(OPE, 32'h0, 16'h0, 16'h0);
    vme_cmd_rd = 1'b1;
    a0 = acc_cnt;
    push_beat(32'h01A84100, 16'h1234);
    pulse_go();
    wait_done("wr1");
    chk("wr1_accepts", acc_cnt - a0, 32'd1);
    chk("wr1_err", {16'h0, err_cnt}, 32'd0);

    // read-compare vectors
    for (int i = 0; i < 4; i++) begin
      clr();
      load(OPR, 32'h00003000, tbl[i].exp_d, tbl[i].mask);
      load(OPE, 32'h0, 16'h0, 16'h0);
      push_beat(32'h02A83000, 16'h0);
      push_rsp(tbl[i].rsp);
      pulse_go();
      wait_done($sformatf("rd%0d", i));
      chk($sformatf("rd%0d_err", i), {16'h0, err_cnt}, {16'h0, tbl[i].err});
      chk($sformatf("rd%0d_tflag", i), {31'h0, timeout_flag}, 32'd0);
      if (tbl[i].err != 0) chk($sformatf("rd%0d_first_err", i), {26'h0, first_err_idx}, 32'd0);
    end

    // timeout on entry 0, entry 1 still issued
    clr();
    load(OPW, 32'h00000010, 16'h0001, 16'h0);
    load(OPW, 32'h00000020, 16'h0002, 16'h0);
    load(OPE, 32'h0, 16'h0, 16'h0);
    vme_cmd_rd = 1'b0;
    push_beat(32'h01A80020, 16'h0002);
    a0 = acc_cnt;
    pulse_go();
    n = 0;
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start) begin
        n++;
        if (vme_cmd_reg !== 32'h01A80010 || vme_dat_reg_in !== 16'h0001) stable = 1'b0;
      end else if (n > 0) begin
        break;
      end
    end
    vme_cmd_rd = 1'b1;
    chk("tmo_start_cycles", n, TMO);
    chk("tmo_stable", {31'h0, stable}, 32'd1);
    wait_done("tmo");
    chk("tmo_flag", {31'h0, timeout_flag}, 32'd1);
    chk("tmo_err", {16'h0, err_cnt}, 32'd1);
    chk("tmo_first_err", {26'h0, first_err_idx}, 32'd0);
    chk("tmo_accepts", acc_cnt - a0, 32'd1);

    // DELAY 5 versus DELAY 0 between two WRITEs
    for (int k = 0; k < 2; k++) begin
      clr();
      load(OPW, 32'h00000100, 16'h000A, 16'h0);
      load(OPD, (k == 0) ? 32'd5 : 32'd0, 16'h0, 16'h0);
      load(OPW, 32'h00000200, 16'h000B, 16'h0);
      load(OPE, 32'h0, 16'h0, 16'h0);
      push_beat(32'h01A80100, 16'h000A);
      push_beat(32'h01A80200, 16'h000B);
      acc_times.delete();
      pulse_go();
      wait_done($sformatf("dly%0d", k));
      chk($sformatf("dly%0d_accepts", k), acc_times.size(), 32'd2);
      gaps[k] = (acc_times.size() == 2) ? acc_times[1] - acc_times[0] : 0;
    end
    chk("dly5_gap_min", {31'h0, gaps[0] >= 6}, 32'd1);
    chk("dly5_vs_dly0", gaps[0] - gaps[1], 32'd4);

    // fill the script, no END: no wrap after entry DEPTH-1
    clr();
    for (int i = 0; i < DEPTH - 1; i++) load(OPW, 32'(i * 16), 16'(i + 256), 16'h0);
    chk("full_at_63", {31'h0, full}, 32'd0);
    load(OPW, 32'((DEPTH - 1) * 16), 16'(DEPTH - 1 + 256), 16'h0);
    chk("full_at_64", {31'h0, full}, 32'd1);
    load(OPW, 32'h00000ABC, 16'hDEAD, 16'h0);
    chk("full_after_extra", {31'h0, full}, 32'd1);
    for (int i = 0; i < DEPTH; i++) push_beat(32'h01A80000 | 32'(i * 16), 16'(i + 256));
    a0 = acc_cnt;
    pulse_go();
    wait_done("full64");
    repeat (4) tick();
    chk("full64_accepts", acc_cnt - a0, DEPTH);

    // abort in WAIT_RSP; loads while busy must not alter the script
    clr();
    load(OPR, 32'h00003000, 16'h0000, 16'hFFFF);
    load(OPE, 32'h0, 16'h0, 16'h0);
    push_beat(32'h02A83000, 16'h0);
    a0 = acc_cnt;
    d0 = done_cnt;
    pulse_go();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (acc_cnt > a0) break;
    end
    chk("abort_accepted", acc_cnt - a0, 32'd1);
    tick();
    clr();
    load(OPW, 32'h00000777, 16'h0777, 16'h0);
    chk("abort_busy_before", {31'h0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_done_pulse", {31'h0, done}, 32'd1);
    tick();
    chk("abort_done_count", done_cnt - d0, 32'd1);
    chk("abort_err", {16'h0, err_cnt}, 32'd0);
    chk("abort_busy_after", {31'h0, busy}, 32'd0);
    push_beat(32'h02A83000, 16'h0);
    push_rsp(16'h0000);
    pulse_go();
    wait_done("abort_rerun");
    chk("abort_rerun_err", {16'h0, err_cnt}, 32'd0);

    // abort during ISSUE drops start combinationally
    clr();
    load(OPW, 32'h00000040, 16'h0040, 16'h0);
    load(OPE, 32'h0, 16'h0, 16'h0);
    vme_cmd_rd = 1'b0;
    pulse_go();
    wait_start("abort_iss");
    abort = 1'b1;
    #1;
    chk("abort_iss_start", {31'h0, start}, 32'd0);
    chk("abort_iss_cmd", vme_cmd_reg, CMASK);
    tick();
    abort = 1'b0;
    wait_done("abort_iss");

    // async reset mid-ISSUE: no done, ld_ptr cleared so go finishes immediately
    clr();
    load(OPW, 32'h00000055, 16'h0055, 16'h0);
    load(OPE, 32'h0, 16'h0, 16'h0);
    pulse_go();
    wait_start("rst_iss");
    d0 = done_cnt;
    a0 = acc_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_iss_start", {31'h0, start}, 32'd0);
    chk("rst_iss_busy", {31'h0, busy}, 32'd0);
    chk("rst_iss_cmd", vme_cmd_reg, CMASK);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("rst_iss_no_done", done_cnt - d0, 32'd0);
    vme_cmd_rd = 1'b1;
    pulse_go();
    @(negedge clk);
    chk("empty_go_done", {31'h0, done}, 32'd1);
    repeat (4) tick();
    chk("empty_go_no_beats", acc_cnt - a0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_script_sequencer.md
Name: vme_script_sequencer

Overview:
- Synthesizable, parametrised successor to the simulation-only VME command file player.
- Holds a script of up to DEPTH entries loaded by a host port: write, read-and-compare, delay or end.
- On start, replays the script into the VME command/data register interface with a ready/valid handshake.
- Checks masked read-back, counts errors and times out stalled commands; used for on-board self-test and bench replay.

Parameters:
DEPTH, 64, number of script entries (power of 2, >=2)
DATA_W, 16, VME data width
CMD_MASK, 32'h00a80000, bits OR'd into every issued command word
TIMEOUT, 1023, max cycles waiting for vme_cmd_rd or vme_dat_wr per entry
ERR_W, 16, error counter width (saturating)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ld_en  in  1  load one script entry at ld_ptr
ld_op  in  2  0=WRITE, 1=READ, 2=DELAY, 3=END
ld_cmd  in  32  VME command word (DELAY: [15:0] = cycle count)
ld_data  in  DATA_W  write data / expected read data
ld_mask  in  DATA_W  compare mask, 1 = bit checked
ld_clr  in  1  reset ld_ptr to 0 (script cleared)
full  out  1  ld_ptr == DEPTH
go  in  1  start replay from entry 0
abort  in  1  stop replay, go to DONE
busy  out  1  replay in progress
done  out  1  one-cycle pulse at replay end
start  out  1  command valid to VME interface
vme_cmd_rd  in  1  VME interface ready; start && vme_cmd_rd = accepted
vme_cmd_reg  out  32  issued command word
vme_dat_reg_in  out  DATA_W  issued write data
vme_dat_wr  in  1  response valid
vme_dat_reg_out  in  DATA_W  response data
rsp_valid  out  1  one-cycle pulse per READ response
rsp_idx  out  log2(DEPTH)  entry index of response
rsp_data  out  DATA_W  response data
err_cnt  out  ERR_W  mismatches + timeouts, saturating
first_err_idx  out  log2(DEPTH)  index of first error; valid when err_cnt != 0
timeout_flag  out  1  sticky, any timeout in this run

Behaviour:
- Reset: all outputs 0, except vme_cmd_reg = CMD_MASK. ld_ptr = 0, FSM = IDLE. Script memory contents are not reset.
- Loading:
  - Only in IDLE. ld_en stores {op,cmd,data,mask} at ld_ptr, then increments ld_ptr. ld_en when full is ignored.
  - ld_clr has priority over ld_en in the same cycle.
  - ld_en / ld_clr while busy are ignored.
- go in IDLE:
  - Clears err_cnt, first_err_idx, timeout_flag; idx = 0; enters FETCH.
  - go with ld_ptr == 0 produces the done pulse one cycle later and no VME traffic.
  - go while busy is ignored.
- FETCH (1 cycle, registered memory read): decode entry idx.
  - WRITE/READ -> ISSUE.
  - DELAY -> DELAY.
  - END, or idx == ld_ptr -> DONE.
- ISSUE:
  - start = 1; vme_cmd_reg = ld_cmd | CMD_MASK, with bit 25 set for READ or bit 24 set for WRITE; vme_dat_reg_in = data (0 for READ).
  - Outputs hold stable until vme_cmd_rd is sampled 1. The accept cycle is the last cycle start = 1.
  - Next state: WRITE -> NEXT; READ -> WAIT_RSP.
  - After accept, vme_cmd_reg returns to CMD_MASK and vme_dat_reg_in to 0.
- WAIT_RSP: on vme_dat_wr, capture rsp_data, assert rsp_valid with rsp_idx = idx in the next cycle, then compare. A mismatch is ((rsp ^ data) & mask) != 0.
- vme_dat_wr outside WAIT_RSP is ignored. A WRITE entry never waits for a response.
- DELAY: count down cmd[15:0] cycles, then NEXT. A count of 0 behaves as 1 cycle.
- NEXT: idx + 1. If idx == DEPTH-1 -> DONE (no wrap), else -> FETCH.
- Timeout: the cycle counter resets on entering ISSUE and WAIT_RSP. Reaching TIMEOUT gives:
  - err_cnt + 1, timeout_flag = 1, start dropped;
  - next state NEXT (the entry is skipped).
- Errors: err_cnt saturates at all-ones. first_err_idx is written only on the 0 -> 1 transition of err_cnt.
- abort: from any busy state, next cycle DONE. start drops immediately and pending responses are discarded.
- DONE: done = 1 for one cycle, then IDLE. busy = 1 in every state except IDLE.
- Async reset mid-run: returns to IDLE at once with start = 0. Script is retained; ld_ptr is cleared.

Test Plan:
- Load W cmd 0x00004100 data 0x1234, then END; go, vme_cmd_rd = 1 -> one accepted beat, vme_cmd_reg = 0x01A84100, vme_dat_reg_in = 0x1234, done, err_cnt = 0.
- Load R 0x00003000 exp 0xBEEF mask 0xFFFF; respond 0xBEEF, then rerun with 0xBEEE -> rsp_valid with rsp_idx = 0 each run; vme_cmd_reg = 0x02A83000; err_cnt 0 then 1; first_err_idx = 0.
- Mask 0x00F0, expected 0x0050, response 0xFF5F -> no error; response 0x0060 -> err_cnt = 1.
- vme_cmd_rd held 0 -> start stays high with stable outputs for TIMEOUT cycles, then timeout_flag = 1, err_cnt = 1, next entry issued.
- DELAY 5 between two W entries -> at least 5 idle cycles between accepts; 64 W entries without END -> 64 accepts, done, no wrap.
- abort during WAIT_RSP, and rst_n asserted mid-ISSUE -> start = 0 immediately, done pulse for abort only; ld_en ignored while busy; full asserts after 64 loads.
